// File: rtl/sub_slice8.sv
// 8-bit ripple-borrow subtractor slice: x - y - borrow-in with borrow-out.
module sub_slice8 (
  input  logic [7:0] x_i,
  input  logic [7:0] y_i,
  input  logic       bin_i,
  output logic [7:0] diff_c_o,
  output logic       bout_c_o
);

  logic [8:0] full_c;

  // A 9-bit difference goes negative exactly when the slice needs a borrow.
  assign full_c   = {1'b0, x_i} - {1'b0, y_i} - 9'(bin_i);
  assign diff_c_o = full_c[7:0];
  assign bout_c_o = full_c[8];

endmodule

// File: rtl/sub_seq_ctrl.sv
// Byte-serial wide subtractor: one 8-bit slice reused LSB-first, borrow chained
// through a register, with a start/busy/done handshake and sticky results.
module sub_seq_ctrl #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [8*NBYTES-1:0] a_i,
  input  logic [8*NBYTES-1:0] b_i,
  input  logic                bin_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [8*NBYTES-1:0] diff_o,
  output logic                bout_o,
  output logic                zero_o
);

  localparam int unsigned W     = 8 * NBYTES;
  localparam int unsigned CNT_W = $clog2(NBYTES);
  localparam int unsigned LAST  = NBYTES - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       work_q, work_d;
  logic               brw_q, brw_d;
  logic               acc_q, acc_d;
  logic [W-1:0]       diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               zero_q, zero_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [CNT_W+2:0]   byte_base;
  logic [7:0]         slice_x;
  logic [7:0]         slice_y;
  logic [7:0]         slice_diff;
  logic               slice_bout;

  assign byte_base = {cnt_q, 3'b000};
  assign slice_x   = a_q[byte_base +: 8];
  assign slice_y   = b_q[byte_base +: 8];

  sub_slice8 u_slice (
    .x_i      (slice_x),
    .y_i      (slice_y),
    .bin_i    (brw_q),
    .diff_c_o (slice_diff),
    .bout_c_o (slice_bout)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    brw_d   = brw_q;
    acc_d   = acc_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;

    case (state_q)
      ST_IDLE: begin
        // abort outranks start, so a simultaneous request is dropped.
        if (start_i && !abort_i) begin
          a_d     = a_i;
          b_d     = b_i;
          brw_d   = bin_i;
          cnt_d   = '0;
          work_d  = '0;
          acc_d   = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          work_d[byte_base +: 8] = slice_diff;
          brw_d                  = slice_bout;
          acc_d                  = acc_q | (slice_diff != 8'd0);
          if (cnt_q == CNT_W'(LAST)) begin
            diff_d  = work_d;
            bout_d  = slice_bout;
            zero_d  = ~acc_d;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake flags are registered copies of the upcoming state.
  assign busy_d = (state_d == ST_RUN);
  assign done_d = (state_d == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      brw_q   <= 1'b0;
      acc_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      brw_q   <= brw_d;
      acc_q   <= acc_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign diff_o = diff_q;
  assign bout_o = bout_q;
  assign zero_o = zero_q;

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Self-checking bench for sub_seq_ctrl: directed and random subtractions compared
// against a plain wide-arithmetic reference.
module tb_sub_seq_ctrl;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i, abort_i, bin_i;
  logic [W-1:0] a_i, b_i;
  logic         busy_o, done_o, bout_o, zero_o;
  logic [W-1:0] diff_o;

  int checks = 0;
  int errors = 0;

  sub_seq_ctrl #(.NBYTES(NB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .abort_i (abort_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .bin_i   (bin_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .diff_o  (diff_o),
    .bout_o  (bout_o),
    .zero_o  (zero_o)
  );

  always #5 clk = ~clk;

  // Reference: a - b - bin in W+1 bits; the top bit is the borrow-out.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bi);
    return {1'b0, a} - {1'b0, b} - (W+1)'(bi);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one operation; returns what was observed, callers do the comparing.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       output int lat, output int nbusy, output logic got_done,
                       output logic [W-1:0] d, output logic bo, output logic z,
                       output logic done_after);
    a_i = a; b_i = b; bin_i = bi; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    a_i = W'($urandom); b_i = W'($urandom); bin_i = 1'($urandom);
    lat = 0; nbusy = 0; got_done = 1'b0;
    d = '0; bo = 1'b0; z = 1'b0;
    while (!got_done && lat < 20) begin
      if (done_o === 1'b1) begin
        got_done = 1'b1;
        d = diff_o; bo = bout_o; z = zero_o;
      end else begin
        if (busy_o === 1'b1) nbusy++;
        tick();
        lat++;
      end
    end
    tick();
    done_after = done_o;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; bin_i = 1'b0; a_i = '0; b_i = '0;
    #1;
    checks++;
    if ({busy_o, done_o, bout_o, zero_o} !== 4'b0000 || diff_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b done=%b diff=%h bout=%b zero=%b required all zero",
               busy_o, done_o, diff_o, bout_o, zero_o);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b done=%b required 0 0", busy_o, done_o);
    end
  endtask

  task automatic test_basic();
    int lat, nb; logic gd, da, bo, z; logic [W-1:0] d;
    do_op(32'h12345678, 32'h00000001, 1'b0, lat, nb, gd, d, bo, z, da);
    checks++;
    if (gd !== 1'b1 || lat != NB) begin
      errors++;
      $display("FAIL basic_latency got_done=%b latency=%0d required 1 %0d", gd, lat, NB);
    end
    checks++;
    if (nb != NB) begin
      errors++;
      $display("FAIL basic_busy_cycles got %0d required %0d", nb, NB);
    end
    checks++;
    if (d !== 32'h12345677 || bo !== 1'b0 || z !== 1'b0) begin
      errors++;
      $display("FAIL basic_result diff=%h bout=%b zero=%b required 12345677 0 0", d, bo, z);
    end
    checks++;
    if (da !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse done=%b one cycle later, required 0", da);
    end
  endtask

  task automatic test_borrow_ripple();
    int lat, nb; logic gd, da, bo, z; logic [W-1:0] d;
    do_op(32'h00000000, 32'h00000001, 1'b0, lat, nb, gd, d, bo, z, da);
    checks++;
    if (gd !== 1'b1 || d !== 32'hFFFFFFFF || bo !== 1'b1 || z !== 1'b0) begin
      errors++;
      $display("FAIL ripple_result done=%b diff=%h bout=%b zero=%b required 1 ffffffff 1 0",
               gd, d, bo, z);
    end
  endtask

  task automatic test_zero();
    int lat, nb; logic gd, da, bo, z; logic [W-1:0] d;
    do_op(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, lat, nb, gd, d, bo, z, da);
    checks++;
    if (gd !== 1'b1 || d !== '0 || bo !== 1'b0 || z !== 1'b1) begin
      errors++;
      $display("FAIL zero_equal done=%b diff=%h bout=%b zero=%b required 1 0 0 1", gd, d, bo, z);
    end
    do_op(32'h00000100, 32'h000000FF, 1'b1, lat, nb, gd, d, bo, z, da);
    checks++;
    if (gd !== 1'b1 || d !== '0 || bo !== 1'b0 || z !== 1'b1) begin
      errors++;
      $display("FAIL zero_cross_byte done=%b diff=%h bout=%b zero=%b required 1 0 0 1",
               gd, d, bo, z);
    end
  endtask

  task automatic test_random();
    int lat, nb; logic gd, da, bo, z; logic [W-1:0] d, a, b; logic bi; logic [W:0] exp;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom); b = W'($urandom); bi = 1'($urandom);
      if (i % 5 == 0) b = a;
      if (i % 7 == 3) b = a - W'(bi) + W'(1);
      exp = ref_sub(a, b, bi);
      do_op(a, b, bi, lat, nb, gd, d, bo, z, da);
      checks++;
      if (gd !== 1'b1 || lat != NB || d !== exp[W-1:0] || bo !== exp[W]
          || z !== (exp[W-1:0] == '0)) begin
        errors++;
        $display("FAIL random_%0d a=%h b=%h bin=%b got done=%b lat=%0d diff=%h bout=%b zero=%b required diff=%h bout=%b zero=%b",
                 i, a, b, bi, gd, lat, d, bo, z, exp[W-1:0], exp[W], (exp[W-1:0] == '0));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] oa [24];
    logic [W-1:0] ob [24];
    logic         obi[24];
    logic [W:0]   exp;
    logic         exp_busy;
    start_i = 1'b1;
    for (int k = 0; k < 24; k++) begin
      oa[k] = W'($urandom); ob[k] = W'($urandom); obi[k] = 1'($urandom);
      a_i = oa[k]; b_i = ob[k]; bin_i = obi[k];
      if (k == 23) start_i = 1'b0;
      tick();
      exp_busy = (k % 6) < 4;
      checks++;
      if (k % 6 == 4) begin
        exp = ref_sub(oa[k-4], ob[k-4], obi[k-4]);
        if (done_o !== 1'b1 || busy_o !== 1'b0 || diff_o !== exp[W-1:0] || bout_o !== exp[W]) begin
          errors++;
          $display("FAIL b2b_edge%0d done=%b busy=%b diff=%h bout=%b required 1 0 %h %b",
                   k, done_o, busy_o, diff_o, bout_o, exp[W-1:0], exp[W]);
        end
      end else if (done_o !== 1'b0 || busy_o !== exp_busy) begin
        errors++;
        $display("FAIL b2b_edge%0d done=%b busy=%b required 0 %b", k, done_o, busy_o, exp_busy);
      end
    end
    start_i = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int lat, nb, spurious; logic gd, da, bo, z; logic [W-1:0] d; logic [W:0] exp;
    do_op(32'h12345678, 32'h00000001, 1'b0, lat, nb, gd, d, bo, z, da);
    a_i = 32'h0F0F0F0F; b_i = 32'h00000003; bin_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || diff_o !== 32'h12345677 || bout_o !== 1'b0
        || zero_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_state busy=%b done=%b diff=%h bout=%b zero=%b required 0 0 12345677 0 0",
               busy_o, done_o, diff_o, bout_o, zero_o);
    end
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done_o !== 1'b0 || busy_o !== 1'b0) spurious++;
    end
    checks++;
    if (spurious != 0 || diff_o !== 32'h12345677) begin
      errors++;
      $display("FAIL abort_quiet activity_cycles=%0d diff=%h required 0 12345677", spurious, diff_o);
    end
    start_i = 1'b1; abort_i = 1'b1; a_i = 32'h5; b_i = 32'h1;
    tick();
    start_i = 1'b0; abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_priority busy=%b required 0", busy_o);
    end
    exp = ref_sub(32'hCAFEF00D, 32'h0BADBEEF, 1'b1);
    do_op(32'hCAFEF00D, 32'h0BADBEEF, 1'b1, lat, nb, gd, d, bo, z, da);
    checks++;
    if (gd !== 1'b1 || lat != NB || d !== exp[W-1:0] || bo !== exp[W]) begin
      errors++;
      $display("FAIL abort_next_op done=%b lat=%0d diff=%h bout=%b required 1 %0d %h %b",
               gd, lat, d, bo, NB, exp[W-1:0], exp[W]);
    end
  endtask

  task automatic test_reset_mid();
    int lat, nb, spurious; logic gd, da, bo, z; logic [W-1:0] d; logic [W:0] exp;
    a_i = 32'h89ABCDEF; b_i = 32'h01234567; bin_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, bout_o, zero_o} !== 4'b0000 || diff_o !== '0) begin
      errors++;
      $display("FAIL midreset_outputs busy=%b done=%b diff=%h bout=%b zero=%b required all zero",
               busy_o, done_o, diff_o, bout_o, zero_o);
    end
    tick();
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done_o !== 1'b0 || busy_o !== 1'b0) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL midreset_quiet activity_cycles=%0d required 0", spurious);
    end
    exp = ref_sub(32'h89ABCDEF, 32'h01234567, 1'b0);
    do_op(32'h89ABCDEF, 32'h01234567, 1'b0, lat, nb, gd, d, bo, z, da);
    checks++;
    if (gd !== 1'b1 || lat != NB || d !== exp[W-1:0] || bo !== exp[W] || z !== 1'b0) begin
      errors++;
      $display("FAIL midreset_fresh_op done=%b lat=%0d diff=%h bout=%b zero=%b required 1 %0d %h %b 0",
               gd, lat, d, bo, z, NB, exp[W-1:0], exp[W]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_ripple();
    test_zero();
    test_random();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
